instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch front end for the MIPS core. Keeps the PC, issues word reads to instruction memory over a request/ack handshake, and buffers returned words in a 2-entry queue. It presents `op`/`func` to the combinational controller and consumes the controller's `Jump` (active-low) and `Branch` (already zero-qualified) outputs to redirect the PC for j, jal, jr, beq and bne.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request, registered level.
- `imem_addr`  out  32  word address, registered; bits [1:0] always 0.
- `imem_ack`  in  1  read data valid; completes the transaction when `imem_req` is high.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `stall`  in  1  downstream cannot accept the head instruction this cycle.
- `Jump`  in  1  from controller, active-low: 0 means j, jal or jr.
- `Branch`  in  1  from controller: 1 means taken beq/bne.
- `rs_data`  in  32  register-file rs value, used as the jr target.
- `instr`  out  32  head instruction; 0 when empty.
- `op`  out  6  `instr[31:26]`.
- `func`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  queue non-empty.
- `pc`  out  32  PC of the head instruction; 0 when empty.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.

## Operation
- **Queue.** 2-entry FIFO of {pc, instr}. The head drives `instr`, `op`, `func`, `pc`.
- **Consume.** A consume occurs when `instr_valid && !stall`. The head is popped at the edge.
- **Redirect.** A redirect occurs on a consume when `Jump==0 || Branch==1`. Target selection:
  - op 6'b000010 or 6'b000011: target = {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - op 0 with func 6'b001000 (jr): target = {`rs_data[31:2]`, 2'b00}, sampled on the consume cycle.
  - Otherwise (branch): target = `pc_plus4` + (sign-extended `instr[15:0]` << 2), 32-bit wrap.
  - A redirect flushes every queued entry, including the popped one.
  - The next fetch address becomes the target.
- **Issue.** A new request may issue when entries + outstanding < 2. At most one transaction is outstanding.
  - While `imem_req` is high and `imem_ack` is low, `imem_addr` is held stable.
  - On the edge where `imem_req && imem_ack`, if space remains after the push, `imem_req` stays high and `imem_addr` steps to the next address, allowing back-to-back fetch.
  - Sequential next address = last address + 4.
- **Discard.** A redirect while a transaction is outstanding (not acked in the same cycle) sets `discard`.
  - The next ack is dropped (not pushed) and `discard` is cleared.
  - `imem_req` then rises on the following edge with the target address.
- **Simultaneous ack and redirect.** The acked data is wrong-path and is dropped. The next `imem_addr` is the target, with `imem_req` high.
- **Simultaneous push and pop without redirect.** The count is unchanged and order is preserved.
- **Full queue.** Fetch stops (`imem_req` 0 after any outstanding ack) until a consume occurs.

## Timing
- **Reset.** Asserting `rst` immediately (asynchronously) forces:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - Queue empty: `instr_valid`=0, `instr`/`op`/`func`/`pc`=0, `pc_plus4`=4.
  - `discard`=0.
  - Any in-flight transaction is forgotten.
- **After reset.** The first rising edge after `rst` deasserts sets `imem_req`=1 with `imem_addr`=`RESET_PC`.
- **Ack to valid.** The ack at edge N makes `instr_valid` high in cycle N+1.
- **Zero-wait memory.** With `imem_ack` tied high, throughput is one instruction per cycle.
- **Redirect latency.** With no transaction outstanding:
  - `instr_valid`=0 and `imem_req`=1 with the target address in the cycle after the redirect.
  - The first target instruction is valid 2 cycles after the redirect.
- **Stall.** `stall` never blocks fetching into free queue space. A stalled head never redirects.

## Test plan
- **Reset and streaming.** Reset with zero-wait memory returning 0x20090001, 0x200A0002, ... -> `imem_addr` 0, 4, 8 on consecutive cycles; `instr_valid` from the 2nd cycle; `pc` 0, 4, 8 in order.
- **Stall.** `stall`=1 for 6 cycles -> 2 entries buffered, `imem_req` low, head `pc` 0 held. Release -> pcs 0, 4, 8 delivered with no gap or duplicate.
- **Jump.** j 0x08000010 at pc 0x8, `Jump`=0 on consume -> entry pc 0xC flushed; next `imem_addr` 0x40; next valid `pc`=0x40.
- **Taken beq.** beq with imm 16'hFFFE at pc 0x20, `Branch`=1 -> target 0x1C; next valid `pc`=0x1C. Same instruction with `Branch`=0 -> `pc` 0x24 follows.
- **jr with outstanding fetch.** jr with `rs_data`=0x103 while fetch 0x24 is outstanding (3-cycle ack latency) -> acked data dropped; next `imem_addr`=0x100; no instruction from 0x24 is ever valid.
- **Mid-transaction reset.** `rst` pulsed asynchronously while `imem_req`=1 and 2 entries are queued -> `imem_req` and `instr_valid` drop before the next edge; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, imem request/ack port, 2-entry instruction queue.
// Redirects on j/jal/jr/taken-branch flush the queue and refetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic [31:0] rs_data,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_t;

  fq_t         q0, q1, q0_n, q1_n, ent;
  logic [1:0]  cnt, cnt_n, pop_cnt;
  logic        req_q, req_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] tgt_q, tgt_n;
  logic        discard, disc_n;

  logic        consume, redirect;
  logic        ack_hit, push;
  logic        is_j, is_jr;
  logic [31:0] imm_ext, target;

  assign instr_valid = (cnt != 2'd0);
  assign instr    = instr_valid ? q0.instr : '0;
  assign pc       = instr_valid ? q0.pc : '0;
  assign op       = instr[31:26];
  assign func     = instr[5:0];
  assign pc_plus4 = pc + 32'd4;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  assign consume  = instr_valid & ~stall;
  assign redirect = consume & (~Jump | Branch);
  assign ack_hit  = req_q & imem_ack;
  assign push     = ack_hit & ~discard & ~redirect;
  assign pop_cnt  = cnt - {1'b0, consume};

  assign is_j    = (op[5:1] == 5'b00001);
  assign is_jr   = (op == 6'd0) && (func == 6'b001000);
  assign imm_ext = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    target = pc_plus4 + imm_ext;
    unique case (1'b1)
      is_j:    target = {pc_plus4[31:28], instr[25:0], 2'b00};
      is_jr:   target = rs_data & 32'hFFFF_FFFC;
      default: target = pc_plus4 + imm_ext;
    endcase
  end

  assign ent = '{pc: addr_q, instr: imem_rdata};

  always_comb begin
    q0_n   = q0;
    q1_n   = q1;
    cnt_n  = cnt;
    req_n  = req_q;
    addr_n = addr_q;
    tgt_n  = tgt_q;
    disc_n = discard;
    if (redirect) begin
      cnt_n = 2'd0;
      // outstanding read must finish at its own address; remember target
      if (req_q && !imem_ack) begin
        disc_n = 1'b1;
        tgt_n  = target;
      end else begin
        req_n  = 1'b1;
        addr_n = target;
      end
    end else begin
      if (consume) q0_n = q1;
      if (push) begin
        if (pop_cnt == 2'd0) q0_n = ent;
        else                 q1_n = ent;
      end
      cnt_n = pop_cnt + {1'b0, push};
      if (ack_hit) begin
        if (discard) begin
          disc_n = 1'b0;
          req_n  = 1'b0;
          addr_n = tgt_q;
        end else begin
          addr_n = addr_q + 32'd4;
          req_n  = (cnt_n < 2'd2);
        end
      end else if (!req_q) begin
        req_n = (cnt_n < 2'd2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0      <= '0;
      q1      <= '0;
      cnt     <= 2'd0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      discard <= 1'b0;
    end else begin
      q0      <= q0_n;
      q1      <= q1_n;
      cnt     <= cnt_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      tgt_q   <= tgt_n;
      discard <= disc_n;
    end
  end

endmodule
